// File: rtl/encoder32_5_pkg.sv
// encoder32_5_pkg
// Shared definitions for the sequential 32-to-5 priority encoder:
//   - line count and code width
//   - slice geometry used by the group-select stage
//   - FSM state encoding
//   - a one-hot helper that builds the pending-clear vector
package encoder32_5_pkg;

    localparam int NLINES  = 32;
    localparam int CODE_W  = 5;
    localparam int GROUP_W = 8;
    localparam int NGROUPS = NLINES / GROUP_W;
    localparam int SUB_W   = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Single set bit at position idx; used to retire the presented line.
    function automatic logic [NLINES-1:0] onehot(input logic [CODE_W-1:0] idx);
        logic [NLINES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/encoder32_5_prio8_3.sv
// prio8_3
// Purely combinational 8-to-3 priority encoder. Bit 7 has the highest
// priority. Four copies cover the 32 pending lines in the top level.
// Ports:
//   req    in  8  active-high request slice
//   code   out 3  index of the highest set bit (0 when none set)
//   active out 1  at least one bit of req is set
module prio8_3
    import encoder32_5_pkg::*;
(
    input  logic [GROUP_W-1:0] req,
    output logic [SUB_W-1:0]   code,
    output logic               active
);

    // Ascending scan: the last (highest) set bit overwrites earlier ones.
    always_comb begin
        code = '0;
        for (int i = 0; i < GROUP_W; i++) begin
            if (req[i]) begin
                code = SUB_W'(i);
            end
        end
    end

    assign active = |req;

endmodule

// File: rtl/encoder32_5.sv
// encoder32_5
// Sequential 32-to-5 priority encoder. Active-low request lines are
// captured into a sticky pending register; the highest-numbered pending
// line is presented as a 5-bit code under a VALID/ACK handshake. While a
// code is presented it is frozen, even if higher requests arrive.
// Ports:
//   clk    in  1   rising-edge clock
//   rst    in  1   synchronous active-high reset
//   E_L    in  1   active-low capture enable (1 blocks new captures only)
//   I_L    in  32  active-low request lines, I_L[i]=0 requests index i
//   ACK    in  1   consumer accepts the presented code (ignored unless VALID)
//   A      out 5   presented code, registered
//   VALID  out 1   A holds a pending index, registered
//   GS_L   out 1   active-low "something pending", registered from next pending
module encoder32_5
    import encoder32_5_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              E_L,
    input  logic [NLINES-1:0] I_L,
    input  logic              ACK,
    output logic [CODE_W-1:0] A,
    output logic              VALID,
    output logic              GS_L
);

    logic [NLINES-1:0] pending;
    logic [NLINES-1:0] pending_nxt;
    logic [NLINES-1:0] clr;
    logic [NLINES-1:0] set;
    logic              ack_take;

    state_t            state;
    state_t            state_nxt;
    logic [CODE_W-1:0] a_nxt;
    logic              valid_nxt;

    logic [SUB_W-1:0]   sub_code [NGROUPS];
    logic [NGROUPS-1:0] grp_act;
    logic [CODE_W-1:0]  code;

    // Per-slice priority encoders over the registered pending vector.
    for (genvar g = 0; g < NGROUPS; g++) begin : g_slice
        prio8_3 u_prio (
            .req    (pending[g*GROUP_W +: GROUP_W]),
            .code   (sub_code[g]),
            .active (grp_act[g])
        );
    end

    // Group select: highest active slice wins; its index forms the top bits.
    always_comb begin
        code = '0;
        for (int s = 0; s < NGROUPS; s++) begin
            if (grp_act[s]) begin
                code = {(CODE_W-SUB_W)'(s), sub_code[s]};
            end
        end
    end

    // Capture / retire. Set is OR-ed after the clear so a line held low
    // during its own ACK re-pends immediately.
    assign ack_take    = (state == PRESENT) && ACK;
    assign clr         = ack_take ? onehot(A) : '0;
    assign set         = ~I_L & {NLINES{~E_L}};
    assign pending_nxt = (pending & ~clr) | set;

    // Handshake FSM: latch a code in IDLE, hold it in PRESENT until ACK.
    always_comb begin
        state_nxt = state;
        a_nxt     = A;
        valid_nxt = VALID;
        case (state)
            IDLE: begin
                if (|pending) begin
                    a_nxt     = code;
                    valid_nxt = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (ACK) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // Register stage: pending, FSM state and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            state   <= IDLE;
            A       <= '0;
            VALID   <= 1'b0;
            GS_L    <= 1'b1;
        end else begin
            pending <= pending_nxt;
            state   <= state_nxt;
            A       <= a_nxt;
            VALID   <= valid_nxt;
            GS_L    <= ~|pending_nxt;
        end
    end

endmodule

// File: tb/tb_encoder32_5.sv
module tb_encoder32_5;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        E_L;
    logic [31:0] I_L;
    logic        ACK;
    logic [4:0]  A;
    logic        VALID;
    logic        GS_L;

    encoder32_5 dut (
        .clk   (clk),
        .rst   (rst),
        .E_L   (E_L),
        .I_L   (I_L),
        .ACK   (ACK),
        .A     (A),
        .VALID (VALID),
        .GS_L  (GS_L)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        e_l;
        logic [31:0] i_l;
        logic        ack;
        logic        exp_valid;
        logic [4:0]  exp_a;
        logic        exp_gs_l;
    } vec_t;

    typedef struct {
        logic       valid;
        logic [4:0] a;
        logic       gs_l;
        string      tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state for the random phase
    logic [31:0] m_pend;
    logic        m_valid;
    logic [4:0]  m_a;
    logic        m_gs_l;

    task automatic row(input logic r, input logic e, input logic [31:0] i, input logic k,
                       input logic v, input logic [4:0] a, input logic g);
        vec_t t;
        t.rst = r; t.e_l = e; t.i_l = i; t.ack = k;
        t.exp_valid = v; t.exp_a = a; t.exp_gs_l = g;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic cycle(input logic r, input logic e, input logic [31:0] i, input logic k,
                         input exp_t ex);
        exp_t got;
        @(negedge clk);
        rst = r; E_L = e; I_L = i; ACK = k;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            got = sb.pop_front();
            check({got.tag, " VALID"}, {31'b0, VALID}, {31'b0, got.valid});
            check({got.tag, " A"},     {27'b0, A},     {27'b0, got.a});
            check({got.tag, " GS_L"},  {31'b0, GS_L},  {31'b0, got.gs_l});
        end
    endtask

    function automatic logic [4:0] highest(input logic [31:0] p);
        for (int i = 31; i >= 0; i--) begin
            if (p[i]) return 5'(i);
        end
        return 5'd0;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [31:0] i, input logic k);
        logic [31:0] np;
        if (r) begin
            m_pend = '0; m_valid = 1'b0; m_a = '0; m_gs_l = 1'b1;
        end else begin
            np = m_pend;
            if (m_valid && k) np[m_a] = 1'b0;
            if (!e) np = np | ~i;
            if (!m_valid) begin
                if (m_pend != 0) begin
                    m_a = highest(m_pend);
                    m_valid = 1'b1;
                end
            end else if (k) begin
                m_valid = 1'b0;
            end
            m_gs_l = (np == 0);
            m_pend = np;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ex;
        logic r, e, k;
        logic [31:0] i;

        rst = 1'b1; E_L = 1'b0; I_L = ONES; ACK = 1'b0;

        //   rst e_l  i_l                           ack  V  A   GS_L
        // Reset with every line requesting, then release
        row(1, 0, 32'h0,                           0,   0, 0,  1);
        row(1, 0, 32'h0,                           0,   0, 0,  1);
        row(0, 0, 32'h0,                           0,   0, 0,  0);
        row(0, 0, ONES,                            0,   1, 31, 0);
        row(1, 0, ONES,                            0,   0, 0,  1);
        // Single request on line 5
        row(0, 0, ~32'h20,                         0,   0, 0,  0);
        row(0, 0, ONES,                            0,   1, 5,  0);
        row(0, 0, ONES,                            1,   0, 5,  1);
        row(0, 0, ONES,                            0,   0, 5,  1);
        // Lines 3, 17, 31 with ACK held high
        row(0, 0, ~32'h8002_0008,                  1,   0, 5,  0);
        row(0, 0, ONES,                            1,   1, 31, 0);
        row(0, 0, ONES,                            1,   0, 31, 0);
        row(0, 0, ONES,                            1,   1, 17, 0);
        row(0, 0, ONES,                            1,   0, 17, 0);
        row(0, 0, ONES,                            1,   1, 3,  0);
        row(0, 0, ONES,                            1,   0, 3,  1);
        row(0, 0, ONES,                            0,   0, 3,  1);
        // Capture blocked by E_L, then enabled
        row(0, 1, ~32'h200,                        0,   0, 3,  1);
        row(0, 1, ~32'h200,                        0,   0, 3,  1);
        row(0, 1, ~32'h200,                        0,   0, 3,  1);
        row(0, 0, ~32'h200,                        0,   0, 3,  0);
        row(0, 0, ONES,                            0,   1, 9,  0);
        row(0, 0, ONES,                            1,   0, 9,  1);
        // Presented code stays frozen while a higher line arrives
        row(0, 0, ~32'h10,                         0,   0, 9,  0);
        row(0, 0, ONES,                            0,   1, 4,  0);
        row(0, 0, ~32'h0010_0000,                  0,   1, 4,  0);
        row(0, 0, ONES,                            0,   1, 4,  0);
        row(0, 0, ONES,                            1,   0, 4,  0);
        row(0, 0, ONES,                            0,   1, 20, 0);
        row(0, 0, ONES,                            1,   0, 20, 1);
        // Held-low line re-pends through its own ACK
        row(0, 0, ~32'h1000,                       0,   0, 20, 0);
        row(0, 0, ~32'h1000,                       0,   1, 12, 0);
        row(0, 0, ~32'h1000,                       1,   0, 12, 0);
        row(0, 0, ~32'h1000,                       0,   1, 12, 0);
        row(0, 0, ONES,                            1,   0, 12, 1);
        // Reset mid-handshake overrides capture
        row(0, 0, ~32'h80,                         0,   0, 12, 0);
        row(0, 0, ONES,                            0,   1, 7,  0);
        row(1, 0, ~32'h80,                         0,   0, 0,  1);
        row(0, 0, ONES,                            0,   0, 0,  1);
        // Pending bit still presented and cleared while E_L blocks capture
        row(0, 0, ~32'h2,                          0,   0, 0,  0);
        row(0, 1, 32'h0,                           0,   1, 1,  0);
        row(0, 1, 32'h0,                           1,   0, 1,  1);
        row(0, 0, ONES,                            0,   0, 1,  1);
        // Slice boundaries: lines 0, 7, 8
        row(0, 0, ~32'h181,                        0,   0, 1,  0);
        row(0, 0, ONES,                            1,   1, 8,  0);
        row(0, 0, ONES,                            1,   0, 8,  0);
        row(0, 0, ONES,                            1,   1, 7,  0);
        row(0, 0, ONES,                            1,   0, 7,  0);
        row(0, 0, ONES,                            1,   1, 0,  0);
        row(0, 0, ONES,                            1,   0, 0,  1);

        foreach (tbl[n]) begin
            ex.valid = tbl[n].exp_valid;
            ex.a     = tbl[n].exp_a;
            ex.gs_l  = tbl[n].exp_gs_l;
            ex.tag   = $sformatf("row%0d", n);
            cycle(tbl[n].rst, tbl[n].e_l, tbl[n].i_l, tbl[n].ack, ex);
        end

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            r = (n == 0) || ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 7) == 0);
            k = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       i = ~(32'h1 << $urandom_range(0, 31));
                1:       i = ~($urandom & $urandom & $urandom);
                default: i = ONES;
            endcase
            model_step(r, e, i, k);
            ex.valid = m_valid;
            ex.a     = m_a;
            ex.gs_l  = m_gs_l;
            ex.tag   = $sformatf("rand%0d", n);
            cycle(r, e, i, k, ex);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
